// File: rtl/mux1hot_if.sv
// Handshake bundle for the registered one-hot mux: producer side (in_*) and consumer side (out_*).
interface mux1hot_if #(
  parameter int unsigned INPUTS = 4,
  parameter int unsigned WIDTH  = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH*INPUTS-1:0]   in;
  logic [WIDTH-1:0]          dflt;
  logic [INPUTS-1:0]         sel;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out;
  logic                      out_dflt;
  logic                      out_err;
  logic                      err_sticky;
  logic                      err_clr;

  modport master (
    output in_valid, in, dflt, sel, out_ready, err_clr,
    input  in_ready, out_valid, out, out_dflt, out_err, err_sticky
  );

  modport slave (
    input  in_valid, in, dflt, sel, out_ready, err_clr,
    output in_ready, out_valid, out, out_dflt, out_err, err_sticky
  );
endinterface

// File: rtl/mux1hot_pipe.sv
// Registered one-hot multiplexer with default/hold word, multi-hot detection and
// a 2-entry output buffer (head = output registers, skid = second entry).
module mux1hot_pipe #(
  parameter int unsigned INPUTS = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HOLD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  mux1hot_if.slave   bus
);

  localparam logic HOLD_EN = (HOLD != 0);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t             state_q, state_d;
  logic               push_c, pop_c;
  logic               load_head_c, head_from_skid_c, load_skid_c;
  logic [WIDTH-1:0]   word_c;
  logic               zero_c, multi_c;

  logic [WIDTH-1:0]   skid_word_q;
  logic               skid_dflt_q, skid_err_q;
  logic [WIDTH-1:0]   hold_q;
  logic               hold_loaded_q;

  assign push_c = bus.in_valid  & bus.in_ready;
  assign pop_c  = bus.out_valid & bus.out_ready;

  // Select decode: OR of selected words; empty select falls back to dflt or held word.
  always_comb begin
    word_c  = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (bus.sel[i]) word_c = word_c | bus.in[i*WIDTH +: WIDTH];
    end
    zero_c  = (bus.sel == '0);
    multi_c = |(bus.sel & (bus.sel - INPUTS'(1)));
    if (zero_c) word_c = (HOLD_EN && hold_loaded_q) ? hold_q : bus.dflt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // Buffer occupancy FSM; FULL never sees a push because in_ready is low there.
  always_comb begin
    state_d          = state_q;
    load_head_c      = 1'b0;
    head_from_skid_c = 1'b0;
    load_skid_c      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (push_c) begin
          state_d     = S_ONE;
          load_head_c = 1'b1;
        end
      end
      S_ONE: begin
        if (push_c && pop_c) begin
          load_head_c = 1'b1;
        end else if (push_c) begin
          state_d     = S_FULL;
          load_skid_c = 1'b1;
        end else if (pop_c) begin
          state_d     = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop_c) begin
          state_d          = S_ONE;
          head_from_skid_c = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Handshake flags follow the next occupancy so neither depends combinationally on the other side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      bus.in_ready  <= (state_d != S_FULL);
      bus.out_valid <= (state_d != S_EMPTY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out      <= '0;
      bus.out_dflt <= 1'b0;
      bus.out_err  <= 1'b0;
    end else if (load_head_c) begin
      bus.out      <= word_c;
      bus.out_dflt <= zero_c;
      bus.out_err  <= multi_c;
    end else if (head_from_skid_c) begin
      bus.out      <= skid_word_q;
      bus.out_dflt <= skid_dflt_q;
      bus.out_err  <= skid_err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_word_q <= '0;
      skid_dflt_q <= 1'b0;
      skid_err_q  <= 1'b0;
    end else if (load_skid_c) begin
      skid_word_q <= word_c;
      skid_dflt_q <= zero_c;
      skid_err_q  <= multi_c;
    end
  end

  // Hold register only captures words chosen by a legal one-hot select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q        <= '0;
      hold_loaded_q <= 1'b0;
    end else if (HOLD_EN && push_c && !zero_c && !multi_c) begin
      hold_q        <= word_c;
      hold_loaded_q <= 1'b1;
    end
  end

  // Clear wins over a same-cycle multi-hot push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    bus.err_sticky <= 1'b0;
    else if (bus.err_clr)       bus.err_sticky <= 1'b0;
    else if (push_c && multi_c) bus.err_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_mux1hot_pipe.sv
// Bench for mux1hot_pipe: HOLD=0 and HOLD=1 instances driven in lockstep, table vectors,
// hand sequences and a randomized run against a queue-based reference model.
module tb_mux1hot_pipe;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux1hot_if #(.INPUTS(N), .WIDTH(W)) bus0 ();
  mux1hot_if #(.INPUTS(N), .WIDTH(W)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in        = bus0.in;
  assign bus1.dflt      = bus0.dflt;
  assign bus1.sel       = bus0.sel;
  assign bus1.out_ready = bus0.out_ready;
  assign bus1.err_clr   = bus0.err_clr;

  mux1hot_pipe #(.INPUTS(N), .WIDTH(W), .HOLD(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mux1hot_pipe #(.INPUTS(N), .WIDTH(W), .HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] word;
    logic         dflt;
    logic         err;
  } beat_t;

  beat_t        q0[$], q1[$];
  logic [W-1:0] m_hold;
  bit           m_loaded, m_sticky, m_push, m_pop;
  int           dut_pops = 0;

  function automatic beat_t model_beat(input logic [W*N-1:0] words, input logic [W-1:0] dflt,
                                       input logic [N-1:0] sel, input bit hold_mode,
                                       input logic [W-1:0] hold, input bit loaded);
    beat_t b;
    int    n;
    n      = $countones(sel);
    b.dflt = (n == 0);
    b.err  = (n > 1);
    b.word = '0;
    if (n == 0) b.word = (hold_mode && loaded) ? hold : dflt;
    else for (int i = 0; i < int'(N); i++) if (sel[i]) b.word = b.word | words[i*W +: W];
    return b;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete();
      m_hold = '0; m_loaded = 0; m_sticky = 0;
    end else begin
      check("mon_out_valid0", 32'(bus0.out_valid), 32'(q0.size() != 0));
      check("mon_out_valid1", 32'(bus1.out_valid), 32'(q1.size() != 0));
      check("mon_in_ready0",  32'(bus0.in_ready),  32'(q0.size() < 2));
      check("mon_in_ready1",  32'(bus1.in_ready),  32'(q1.size() < 2));
      check("mon_sticky0",    32'(bus0.err_sticky), 32'(m_sticky));
      check("mon_sticky1",    32'(bus1.err_sticky), 32'(m_sticky));
      if (q0.size() > 0) begin
        check("mon_out0",  32'(bus0.out),      32'(q0[0].word));
        check("mon_dflt0", 32'(bus0.out_dflt), 32'(q0[0].dflt));
        check("mon_err0",  32'(bus0.out_err),  32'(q0[0].err));
        check("mon_out1",  32'(bus1.out),      32'(q1[0].word));
        check("mon_dflt1", 32'(bus1.out_dflt), 32'(q1[0].dflt));
        check("mon_err1",  32'(bus1.out_err),  32'(q1[0].err));
      end
      if (bus0.out_valid && bus0.out_ready) dut_pops++;
      m_push = bus0.in_valid && (q0.size() < 2);
      m_pop  = (q0.size() > 0) && bus0.out_ready;
      if (m_pop) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (m_push) begin
        beat_t b1;
        q0.push_back(model_beat(bus0.in, bus0.dflt, bus0.sel, 1'b0, m_hold, m_loaded));
        b1 = model_beat(bus0.in, bus0.dflt, bus0.sel, 1'b1, m_hold, m_loaded);
        q1.push_back(b1);
        if ($countones(bus0.sel) == 1) begin
          m_hold   = b1.word;
          m_loaded = 1;
        end
      end
      if (bus0.err_clr) m_sticky = 0;
      else if (m_push && $countones(bus0.sel) > 1) m_sticky = 1;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [W*N-1:0] words;
    logic [W-1:0]   dflt;
    logic [N-1:0]   sel;
    logic [W-1:0]   e0;
    logic [W-1:0]   e1;
    logic           ed;
    logic           ee;
  } vec_t;

  vec_t tv[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W*N-1:0] words, input logic [W-1:0] dflt,
                       input logic [N-1:0] sel);
    bus0.in_valid = v;
    bus0.in       = words;
    bus0.dflt     = dflt;
    bus0.sel      = sel;
  endtask

  initial begin : main
    int pushes, cycles;
    logic [N-1:0] rsel;

    tv[0] = '{32'h44332211, 8'hA5, 4'b0000, 8'hA5, 8'hA5, 1'b1, 1'b0};
    tv[1] = '{32'h44332211, 8'hFF, 4'b0100, 8'h33, 8'h33, 1'b0, 1'b0};
    tv[2] = '{32'h44332211, 8'hA5, 4'b0000, 8'hA5, 8'h33, 1'b1, 1'b0};
    tv[3] = '{32'h4433F00F, 8'h00, 4'b0011, 8'hFF, 8'hFF, 1'b0, 1'b1};
    tv[4] = '{32'h44332211, 8'h5A, 4'b0000, 8'h5A, 8'h33, 1'b1, 1'b0};
    tv[5] = '{32'h44332211, 8'h00, 4'b1000, 8'h44, 8'h44, 1'b0, 1'b0};
    tv[6] = '{32'h44332211, 8'h00, 4'b1111, 8'h77, 8'h77, 1'b0, 1'b1};
    tv[7] = '{32'h44332211, 8'h00, 4'b0000, 8'h00, 8'h44, 1'b1, 1'b0};
    tv[8] = '{32'h44332211, 8'hEE, 4'b0001, 8'h11, 8'h11, 1'b0, 1'b0};
    tv[9] = '{32'h44332211, 8'h12, 4'b0010, 8'h22, 8'h22, 1'b0, 1'b0};

    drive(1'b0, '0, '0, '0);
    bus0.out_ready = 1'b1;
    bus0.err_clr   = 1'b0;

    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus0.in_ready),  32'd1);
    check("rst_out",       32'(bus0.out),       32'd0);
    check("rst_out_dflt",  32'(bus1.out_dflt),  32'd0);
    check("rst_out_err",   32'(bus1.out_err),   32'd0);
    check("rst_sticky",    32'(bus1.err_sticky), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Table vectors: one beat per cycle, output checked one cycle after its push.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, tv[k].words, tv[k].dflt, tv[k].sel);
      step();
      bus0.in_valid = 1'b0;
      check($sformatf("tv%0d_valid", k), 32'(bus0.out_valid), 32'd1);
      check($sformatf("tv%0d_out0", k),  32'(bus0.out),       32'(tv[k].e0));
      check($sformatf("tv%0d_out1", k),  32'(bus1.out),       32'(tv[k].e1));
      check($sformatf("tv%0d_dflt", k),  32'(bus0.out_dflt),  32'(tv[k].ed));
      check($sformatf("tv%0d_err", k),   32'(bus1.out_err),   32'(tv[k].ee));
    end
    step();
    check("sticky_set0", 32'(bus0.err_sticky), 32'd1);
    check("sticky_set1", 32'(bus1.err_sticky), 32'd1);

    // err_clr alone, then err_clr colliding with a multi-hot push.
    bus0.err_clr = 1'b1;
    step();
    bus0.err_clr = 1'b0;
    check("sticky_clr", 32'(bus0.err_sticky), 32'd0);
    drive(1'b1, 32'h4433F00F, 8'h00, 4'b0011);
    bus0.err_clr = 1'b1;
    step();
    bus0.in_valid = 1'b0;
    bus0.err_clr  = 1'b0;
    check("clr_coll_out", 32'(bus0.out),        32'hFF);
    check("clr_coll_err", 32'(bus0.out_err),    32'd1);
    check("clr_coll_stk", 32'(bus0.err_sticky), 32'd0);
    step();
    check("clr_coll_stk2", 32'(bus1.err_sticky), 32'd0);

    // Backpressure: three offered beats, two accepted, then drain in order.
    bus0.out_ready = 1'b0;
    drive(1'b1, 32'h04030201, 8'h00, 4'b0001);
    step();
    check("bp_ready1", 32'(bus0.in_ready), 32'd1);
    bus0.sel = 4'b0010;
    step();
    check("bp_ready2", 32'(bus0.in_ready), 32'd0);
    check("bp_out2",   32'(bus0.out),      32'h01);
    bus0.sel = 4'b0100;
    step();
    check("bp_ready3", 32'(bus0.in_ready), 32'd0);
    check("bp_out3",   32'(bus0.out),      32'h01);
    check("bp_valid3", 32'(bus0.out_valid), 32'd1);
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    step();
    check("bp_drain1",  32'(bus0.out),      32'h02);
    check("bp_ready_d", 32'(bus0.in_ready), 32'd1);
    step();
    check("bp_drain2",  32'(bus0.out_valid), 32'd0);

    // Randomized continuous push with random out_ready.
    pushes   = 0;
    cycles   = 0;
    dut_pops = 0;
    while (pushes < 1000 && cycles < 5000) begin
      case ($urandom_range(0, 3))
        0:       rsel = '0;
        1, 2:    rsel = N'(1) << $urandom_range(0, N - 1);
        default: rsel = N'($urandom);
      endcase
      drive(1'b1, (W*N)'($urandom), W'($urandom), rsel);
      bus0.out_ready = 1'($urandom_range(0, 1));
      bus0.err_clr   = ($urandom_range(0, 15) == 0);
      if (bus0.in_ready) pushes++;
      step();
      cycles++;
    end
    check("rand_pushes", 32'(pushes), 32'd1000);
    bus0.in_valid  = 1'b0;
    bus0.err_clr   = 1'b0;
    bus0.out_ready = 1'b1;
    repeat (3) step();
    check("rand_pops",    32'(dut_pops),       32'(pushes));
    check("rand_drained", 32'(bus1.out_valid), 32'd0);

    // Async reset with two beats buffered and sticky set.
    bus0.out_ready = 1'b0;
    drive(1'b1, 32'h4433F00F, 8'h00, 4'b0011);
    step();
    bus0.sel = 4'b0001;
    step();
    bus0.in_valid = 1'b0;
    check("pre_rst_sticky", 32'(bus0.err_sticky), 32'd1);
    check("pre_rst_ready",  32'(bus0.in_ready),   32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid0",  32'(bus0.out_valid),  32'd0);
    check("arst_valid1",  32'(bus1.out_valid),  32'd0);
    check("arst_ready",   32'(bus0.in_ready),   32'd1);
    check("arst_sticky",  32'(bus1.err_sticky), 32'd0);
    check("arst_out",     32'(bus0.out),        32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus0.out_ready = 1'b1;
    step();

    // Hold mode right after reset falls back to dflt.
    drive(1'b1, 32'h44332211, 8'hA5, 4'b0000);
    step();
    bus0.in_valid = 1'b0;
    check("hold_rst_out1", 32'(bus1.out),      32'hA5);
    check("hold_rst_dflt", 32'(bus1.out_dflt), 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
